// File: rtl/sprite_bank_writer.sv
// rtl/sprite_bank_writer.sv - double-banked sprite memory loader with frame-synchronous bank swap
module sprite_bank_writer #(
    parameter int SPRITE_W = 64,
    parameter int SPRITE_H = 64,
    parameter int COLOR_W  = 3,
    parameter int ADDR_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               in_valid,
    input  logic [COLOR_W-1:0] in_color,
    output logic               in_ready,
    input  logic               frame_start,
    output logic               wr_en,
    output logic [ADDR_W:0]    wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    output logic               rd_bank,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_SWAP = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SPRITE_W * SPRITE_H - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] count;
    logic              accept;
    logic              swap;
    logic              clear_count;

    // abort masks in_ready so a pixel offered alongside it is never written
    assign in_ready = (state == LOAD) && !abort;
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next  = state;
        swap        = 1'b0;
        clear_count = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next  = LOAD;
                    clear_count = 1'b1;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (accept && (count == LAST_ADDR)) begin
                    state_next = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (frame_start) begin
                    state_next = IDLE;
                    swap       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear_count) begin
            count <= '0;
        end else if (accept) begin
            count <= count + 1'b1;
        end
    end

    // Writes always target the bank the printer is not reading
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_addr <= {~rd_bank, count};
                wr_data <= in_color;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_bank <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= swap;
            if (swap) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_sprite_bank_writer.sv
// tb/tb_sprite_bank_writer.sv - scoreboard bench for sprite_bank_writer
module tb_sprite_bank_writer;

    localparam int NPIX = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_color = '0;
    logic        in_ready;
    logic        frame_start = 1'b0;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [2:0]  wr_data;
    logic        rd_bank;
    logic        busy;
    logic        done;

    int compared = 0;
    int mismatched = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic exp_bank = 1'b0;
    logic [15:0] exp_q[$];

    sprite_bank_writer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_color(in_color), .in_ready(in_ready),
        .frame_start(frame_start), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_bank(rd_bank), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected {addr,data} per observed write
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && wr_en === 1'b1) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {19'd0, wr_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("write", {16'd0, wr_addr, wr_data}, {16'd0, e});
                end
            end
            if (rst === 1'b1 && done === 1'b1) done_cnt++;
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Streams n accepted pixels; optionally raises frame_start with the last one
    task automatic stream(input int n, input int idle_pct, input bit fs_last);
        int k = 0;
        int guard = 0;
        while (k < n) begin
            @(negedge clk);
            in_valid    = ($urandom_range(99) >= idle_pct);
            in_color    = 3'(k % 8);
            frame_start = fs_last && (k == n - 1) && in_valid;
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back({~exp_bank, 12'(k), 3'(k % 8)});
                k++;
            end
            guard++;
            if (guard > 20000) begin
                check("stream_timeout", 32'(k), 32'(n));
                break;
            end
        end
        @(negedge clk);
        in_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic pulse_fs();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int w0;
        int d0;

        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rd_bank", 32'(rd_bank), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b1;

        // in_valid while IDLE produces no write
        @(negedge clk);
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;

        // Full load into bank 1, no gaps
        do_start();
        check("load_busy", 32'(busy), 1);
        stream(NPIX, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("wait_busy", 32'(busy), 1);
        check("wait_in_ready", 32'(in_ready), 0);
        check("wait_rd_bank", 32'(rd_bank), 0);
        check("load1_wr_cnt", 32'(wr_cnt), NPIX);
        check("load1_q_empty", 32'(exp_q.size()), 0);
        // start and in_valid ignored in WAIT_SWAP
        in_valid = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        start = 1'b0;
        pulse_fs();
        exp_bank = 1'b1;
        check("swap1_rd_bank", 32'(rd_bank), 1);
        check("swap1_done_cnt", 32'(done_cnt), 1);
        check("swap1_busy", 32'(busy), 0);

        // Second load into bank 0 with gaps; frame_start coincides with last acceptance
        w0 = wr_cnt;
        do_start();
        stream(NPIX, 30, 1'b1);
        repeat (800) @(negedge clk);
        check("gap_wr_cnt", 32'(wr_cnt - w0), NPIX);
        check("gap_q_empty", 32'(exp_q.size()), 0);
        check("fs_last_no_swap", 32'(rd_bank), 1);
        check("fs_last_no_done", 32'(done_cnt), 1);
        check("fs_last_busy", 32'(busy), 1);
        pulse_fs();
        exp_bank = 1'b0;
        check("swap2_rd_bank", 32'(rd_bank), 0);
        check("swap2_done_cnt", 32'(done_cnt), 2);

        // Abort at pixel 2000
        do_start();
        stream(2000, 0, 1'b0);
        abort = 1'b1;
        in_valid = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        abort = 1'b0;
        w0 = wr_cnt;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        check("abort_no_writes", 32'(wr_cnt - w0), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_rd_bank", 32'(rd_bank), 0);
        check("abort_no_done", 32'(done_cnt), 2);
        check("abort_q_empty", 32'(exp_q.size()), 0);

        // Restart from addr 0, then abort wins over simultaneous frame_start
        do_start();
        stream(NPIX, 10, 1'b0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_fs_rd_bank", 32'(rd_bank), 0);
        check("abort_fs_done", 32'(done_cnt), 2);
        check("abort_fs_busy", 32'(busy), 0);
        check("abort_fs_q_empty", 32'(exp_q.size()), 0);

        // Load and swap to bank 1, then reset mid-load
        do_start();
        stream(NPIX, 0, 1'b0);
        pulse_fs();
        exp_bank = 1'b1;
        check("swap3_rd_bank", 32'(rd_bank), 1);
        do_start();
        stream(1000, 0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        exp_q.delete();
        check("arst_rd_bank", 32'(rd_bank), 0);
        check("arst_wr_en", 32'(wr_en), 0);
        check("arst_wr_addr", 32'(wr_addr), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_in_ready", 32'(in_ready), 0);
        check("arst_done", 32'(done), 0);
        exp_bank = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        rst = 1'b1;

        // After reset a load restarts at addr 0 into bank 1
        do_start();
        stream(16, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("post_rst_q_empty", 32'(exp_q.size()), 0);
        check("post_rst_no_done", 32'(done_cnt - d0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
